// File: rtl/char_pkg.sv
// Shared ASCII constants and conversion result type for the character FIFO.
package char_pkg;

  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  typedef struct packed {
    logic [7:0] data;
    logic       lower;
  } conv_res_t;

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= ASCII_LC_A) && (b <= ASCII_LC_Z);
  endfunction

endpackage

// File: rtl/char_case_conv.sv
// Combinational lowercase-to-uppercase converter; non-letters (including >= 0x80) pass unchanged.
module char_case_conv
  import char_pkg::*;
(
  input  logic [7:0] in_byte,
  output conv_res_t  res
);

  always_comb begin
    res.lower = is_lower(in_byte);
    res.data  = res.lower ? (in_byte - CASE_OFFSET) : in_byte;
  end

endmodule

// File: rtl/char_stream_fifo.sv
// Byte FIFO with registered output storage, full pass-through and sticky overflow.
// Optional write-path case conversion and letter counter enabled by CASE_CONV_EN.
module char_stream_fifo
  import char_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CW-1:0]              conv_cnt,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    wr_byte;
  logic          push, pop;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign out_valid = (level_q != '0);
  assign in_ready  = (level_q < LW'(DEPTH)) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rptr_q];
  assign level     = level_q;
  assign overflow  = ovf_q;

`ifdef CASE_CONV_EN
  conv_res_t     conv_res;
  logic [CW-1:0] conv_q, conv_d;

  char_case_conv u_conv (
    .in_byte (in_data),
    .res     (conv_res)
  );

  assign wr_byte = conv_res.data;

  always_comb begin
    conv_d = conv_q;
    if (push && conv_res.lower && !(&conv_q)) conv_d = conv_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) conv_q <= '0;
    else     conv_q <= conv_d;
  end

  assign conv_cnt = conv_q;
`else
  assign wr_byte  = in_data;
  assign conv_cnt = '0;
`endif

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q | (in_valid & ~in_ready);
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is not reset; at full pass-through the written slot is the one being vacated.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= wr_byte;
  end

endmodule
